// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial BCD adder
//
// Purpose: sequencer state encoding and packed-BCD digit constants used by
// bcd_digit_add and bcd_serial_add_ctrl.
// Ports: none (package).

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder stage
//
// Purpose: adds two BCD digits plus a decimal carry and applies the +6
// correction when the binary sum exceeds 9. Out-of-range digits are not
// saturated; they follow the same rule and are flagged instead.
// Ports:
//   ad, bd     in  BCD_DIGIT_W  operand digits
//   c          in  1            decimal carry-in
//   digit      out BCD_DIGIT_W  corrected result digit
//   c_out      out 1            decimal carry-out
//   bad_digit  out 1            ad or bd was greater than 9

module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] ad,
  input  logic [BCD_DIGIT_W-1:0] bd,
  input  logic                   c,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   c_out,
  output logic                   bad_digit
);

  localparam logic [BCD_DIGIT_W:0]   MAX_RAW   = (BCD_DIGIT_W+1)'(BCD_MAX);
  localparam logic [BCD_DIGIT_W-1:0] MAX_DIGIT = BCD_DIGIT_W'(BCD_MAX);
  localparam logic [BCD_DIGIT_W-1:0] CORR      = BCD_DIGIT_W'(BCD_CORR);

  // One extra bit so 15+15+1 does not wrap before the range test.
  logic [BCD_DIGIT_W:0] raw;

  assign raw = {1'b0, ad} + {1'b0, bd} + {{BCD_DIGIT_W{1'b0}}, c};

  always_comb begin
    digit = raw[BCD_DIGIT_W-1:0];
    c_out = 1'b0;
    if (raw > MAX_RAW) begin
      // Adding 6 modulo 16 skips the six unused codes A..F.
      digit = raw[BCD_DIGIT_W-1:0] + CORR;
      c_out = 1'b1;
    end
  end

  assign bad_digit = (ad > MAX_DIGIT) || (bd > MAX_DIGIT);

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder sequencer
//
// Purpose: adds two DIGITS-wide packed-BCD operands one digit per clock,
// least-significant digit first, through a single bcd_digit_add stage.
// Ports:
//   clk      in  1         rising-edge clock
//   rst      in  1         asynchronous active-high reset
//   start    in  1         request; honoured only in IDLE or DONE
//   a, b     in  4*DIGITS  packed BCD operands, digit 0 in bits [3:0]
//   cin      in  1         decimal carry-in to digit 0
//   busy     out 1         high while digits are being processed
//   done     out 1         one-cycle pulse when sum/cout/invalid are valid
//   sum      out 4*DIGITS  packed BCD result
//   cout     out 1         decimal carry-out of the top digit
//   invalid  out 1         some processed input digit was greater than 9

module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   b,
  input  logic                            cin,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   sum,
  output logic                            cout,
  output logic                            invalid
);

  localparam int W  = BCD_DIGIT_W * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  bcd_state_e            state, state_n;
  logic [W-1:0]          a_sr, b_sr;
  logic                  carry;
  logic [CW-1:0]         cnt;
  logic                  capture;
  logic                  last_digit;

  logic [BCD_DIGIT_W-1:0] digit;
  logic                   digit_c;
  logic                   digit_bad;

  bcd_digit_add u_digit (
    .ad        (a_sr[BCD_DIGIT_W-1:0]),
    .bd        (b_sr[BCD_DIGIT_W-1:0]),
    .c         (carry),
    .digit     (digit),
    .c_out     (digit_c),
    .bad_digit (digit_bad)
  );

  assign last_digit = (cnt == LAST_CNT);

  always_comb begin
    state_n = state;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          capture = 1'b1;
        end
      end
      RUN: begin
        if (last_digit) state_n = DONE;
      end
      DONE: begin
        // Back-to-back starts are accepted here so throughput stays at one
        // add per DIGITS+1 cycles.
        if (start) begin
          state_n = RUN;
          capture = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      state <= state_n;
      if (capture) begin
        a_sr    <= a;
        b_sr    <= b;
        carry   <= cin;
        cnt     <= '0;
        sum     <= '0;
        cout    <= 1'b0;
        invalid <= 1'b0;
      end else if (state == RUN) begin
        // Operands shift down so the active digit is always at [3:0]; result
        // digits enter from the top so digit 0 lands at [3:0] after DIGITS.
        a_sr    <= a_sr >> BCD_DIGIT_W;
        b_sr    <= b_sr >> BCD_DIGIT_W;
        sum     <= {digit, sum[W-1:BCD_DIGIT_W]};
        carry   <= digit_c;
        invalid <= invalid | digit_bad;
        cnt     <= cnt + CW'(1);
        if (last_digit) cout <= digit_c;
      end
    end
  end

endmodule
